// File: rtl/fpga_puf_burst_issuer.sv
// rtl/fpga_puf_burst_issuer.sv - splits a beat transfer into bursts with an outstanding-burst limit
module fpga_puf_burst_issuer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_WIDTH      = 32,
  parameter int C_BYTES_PER_BEAT  = 64,
  parameter int C_MAX_BURST       = 16,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [C_XFER_WIDTH-1:0] ctrl_beats,
  output logic                    ctrl_busy,
  output logic                    ctrl_done,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [C_ADDR_WIDTH-1:0] req_addr,
  output logic [7:0]              req_len,
  input  logic                    cmpl,
  output logic [7:0]              outstanding,
  output logic                    err_underflow
);

  localparam int                    BEAT_SHIFT  = $clog2(C_BYTES_PER_BEAT);
  localparam logic [C_XFER_WIDTH-1:0] MAX_BURST_X = C_XFER_WIDTH'(C_MAX_BURST);
  localparam logic [C_XFER_WIDTH-1:0] ONE_X       = C_XFER_WIDTH'(1);
  localparam logic [7:0]            MAX_OUT_8   = 8'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_XFER_WIDTH-1:0] remain_q, remain_d;
  logic [7:0]              outst_q, outst_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [C_XFER_WIDTH-1:0] burst_len;
  logic                    handshake;
  logic                    start_acc;
  logic                    underflow;

  // Current burst size and the request presented to the fabric
  always_comb begin
    burst_len = (remain_q > MAX_BURST_X) ? MAX_BURST_X : remain_q;
    req_valid = (state_q == ST_ISSUE) && (remain_q != '0) && (outst_q < MAX_OUT_8);
    req_len   = (remain_q == '0) ? 8'd0 : 8'(burst_len - ONE_X);
    req_addr  = addr_q;
    handshake = req_valid && req_ready;
  end

  // Outstanding counter, sticky error and FSM next state
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    outst_d   = outst_q;
    busy_d    = busy_q;
    start_acc = 1'b0;
    underflow = 1'b0;

    // A simultaneous issue and completion cancel out
    if (handshake && !cmpl) begin
      outst_d = outst_q + 8'd1;
    end else if (!handshake && cmpl) begin
      if (outst_q == 8'd0) underflow = 1'b1;
      else                 outst_d   = outst_q - 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          start_acc = 1'b1;
          addr_d    = ctrl_addr;
          remain_d  = ctrl_beats;
          busy_d    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A zero-beat transfer has nothing to issue or drain
        if (remain_q == '0) begin
          state_d = ST_DONE;
        end else if (handshake) begin
          addr_d   = addr_q + (C_ADDR_WIDTH'(burst_len) << BEAT_SHIFT);
          remain_d = remain_q - burst_len;
          if (remain_q == burst_len) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outst_d == 8'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = (err_q && !start_acc) || underflow;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      outst_q  <= 8'd0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign ctrl_done     = (state_q == ST_DONE);
  assign ctrl_busy     = busy_q;
  assign outstanding   = outst_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fpga_puf_burst_issuer.sv
// tb/tb_fpga_puf_burst_issuer.sv - directed bench for fpga_puf_burst_issuer
module tb_fpga_puf_burst_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [63:0] ctrl_addr = '0;
  logic [31:0] ctrl_beats = '0;
  logic        req_ready = 1'b0;
  logic        cmpl = 1'b0;

  logic        a_busy, a_done, a_valid, a_err;
  logic [63:0] a_addr;
  logic [7:0]  a_len, a_outst;
  logic        b_busy, b_done, b_valid, b_err;
  logic [63:0] b_addr;
  logic [7:0]  b_len, b_outst;

  int          total = 0;
  int          bad = 0;
  int          nhs;
  int          ndone;
  logic [1:0]  pipe;
  logic [63:0] exp_addr [3];
  logic [7:0]  exp_len [3];

  fpga_puf_burst_issuer dut_a (
    .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_beats(ctrl_beats), .ctrl_busy(a_busy), .ctrl_done(a_done),
    .req_valid(a_valid), .req_ready(req_ready), .req_addr(a_addr), .req_len(a_len),
    .cmpl(cmpl), .outstanding(a_outst), .err_underflow(a_err)
  );

  fpga_puf_burst_issuer #(.C_MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_beats(ctrl_beats), .ctrl_busy(b_busy), .ctrl_done(b_done),
    .req_valid(b_valid), .req_ready(req_ready), .req_addr(b_addr), .req_len(b_len),
    .cmpl(cmpl), .outstanding(b_outst), .err_underflow(b_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ctrl_start = 1'b0; req_ready = 1'b0; cmpl = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start(input logic [63:0] addr, input logic [31:0] beats);
    ctrl_start = 1'b1; ctrl_addr = addr; ctrl_beats = beats;
    tick();
    ctrl_start = 1'b0;
  endtask

  initial begin
    // reset values
    #2;
    check("rst_valid", a_valid, 0);
    check("rst_busy",  a_busy, 0);
    check("rst_done",  a_done, 0);
    check("rst_outst", a_outst, 0);
    check("rst_err",   a_err, 0);
    check("rst_addr",  a_addr, 0);
    check("rst_len",   a_len, 0);

    // 40 beats from 0x1000, completion two cycles after each handshake
    exp_addr[0] = 64'h1000; exp_len[0] = 8'd15;
    exp_addr[1] = 64'h1400; exp_len[1] = 8'd15;
    exp_addr[2] = 64'h1800; exp_len[2] = 8'd7;
    do_reset();
    req_ready = 1'b1;
    start(64'h1000, 32'd40);
    check("t1_busy", a_busy, 1);
    nhs = 0; ndone = 0; pipe = 2'b00;
    for (int c = 0; c < 12; c++) begin
      cmpl = pipe[1];
      #1;
      if (a_valid && req_ready) begin
        if (nhs < 3) begin
          check("t1_addr", a_addr, exp_addr[nhs]);
          check("t1_len",  a_len,  exp_len[nhs]);
        end
        nhs++;
      end
      if (a_done) ndone++;
      pipe = {pipe[0], a_valid && req_ready};
      tick();
    end
    cmpl = 1'b0;
    check("t1_nhs",   nhs, 3);
    check("t1_ndone", ndone, 1);
    check("t1_outst", a_outst, 0);
    check("t1_busy_end", a_busy, 0);

    // outstanding limit of 2, no completions
    do_reset();
    req_ready = 1'b1;
    start(64'h0, 32'd64);
    nhs = 0;
    for (int c = 0; c < 6; c++) begin
      if (b_valid && req_ready) nhs++;
      tick();
    end
    check("t2_nhs",   nhs, 2);
    check("t2_valid", b_valid, 0);
    check("t2_outst", b_outst, 2);
    cmpl = 1'b1;
    #1;
    check("t2_valid_cmpl_cycle", b_valid, 0);
    tick();
    cmpl = 1'b0;
    check("t2_valid3", b_valid, 1);
    check("t2_addr3",  b_addr, 64'h800);
    check("t2_len3",   b_len, 15);
    check("t2_outst3", b_outst, 1);

    // back-pressure hold, then handshake coinciding with completion
    do_reset();
    req_ready = 1'b0;
    start(64'h2000, 32'd20);
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", a_valid, 1);
      check("t3_hold_addr",  a_addr, 64'h2000);
      check("t3_hold_len",   a_len, 15);
      tick();
    end
    req_ready = 1'b1;
    tick();
    check("t3_outst1", a_outst, 1);
    check("t3_addr2",  a_addr, 64'h2400);
    check("t3_len2",   a_len, 3);
    cmpl = 1'b1;
    tick();
    check("t3_outst_same", a_outst, 1);
    check("t3_valid_drain", a_valid, 0);
    tick();
    cmpl = 1'b0; req_ready = 1'b0;
    check("t3_done",  a_done, 1);
    check("t3_outst0", a_outst, 0);
    tick();
    check("t3_busy_end", a_busy, 0);

    // zero beats; a start while busy is ignored
    do_reset();
    start(64'h3000, 32'd0);
    check("t4_valid1", a_valid, 0);
    check("t4_done1",  a_done, 0);
    check("t4_busy1",  a_busy, 1);
    ctrl_start = 1'b1; ctrl_addr = 64'h5000; ctrl_beats = 32'd5;
    tick();
    check("t4_done2",  a_done, 1);
    check("t4_valid2", a_valid, 0);
    tick();
    ctrl_start = 1'b0;
    check("t4_done3", a_done, 0);
    check("t4_busy3", a_busy, 0);
    tick();
    check("t4_valid4", a_valid, 0);
    check("t4_busy4",  a_busy, 0);

    // completion in IDLE sets the sticky error; next start clears it
    do_reset();
    cmpl = 1'b1;
    tick();
    cmpl = 1'b0;
    check("t5_err",   a_err, 1);
    check("t5_outst", a_outst, 0);
    tick();
    check("t5_err_sticky", a_err, 1);
    req_ready = 1'b1;
    start(64'h40, 32'd1);
    check("t5_err_clr", a_err, 0);
    check("t5_valid",   a_valid, 1);
    check("t5_addr",    a_addr, 64'h40);
    check("t5_len",     a_len, 0);
    tick();
    cmpl = 1'b1;
    tick();
    cmpl = 1'b0;
    check("t5_done", a_done, 1);

    // asynchronous reset in the middle of ISSUE
    do_reset();
    req_ready = 1'b1;
    start(64'h0, 32'd100);
    tick(); tick(); tick();
    check("t6_outst_pre", a_outst, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", a_valid, 0);
    check("t6_busy",  a_busy, 0);
    check("t6_done",  a_done, 0);
    check("t6_outst", a_outst, 0);
    check("t6_addr",  a_addr, 0);
    check("t6_len",   a_len, 0);
    ndone = 0;
    tick();
    if (a_done) ndone++;
    tick();
    rst_n = 1'b1;
    if (a_done) ndone++;
    tick();
    if (a_done) ndone++;
    check("t6_no_done", ndone, 0);
    start(64'h80, 32'd1);
    check("t6_valid_new", a_valid, 1);
    check("t6_addr_new",  a_addr, 64'h80);
    check("t6_len_new",   a_len, 0);
    tick();
    cmpl = 1'b1;
    tick();
    cmpl = 1'b0;
    check("t6_done_new", a_done, 1);
    tick();
    check("t6_busy_end", a_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
